// File: rtl/bcd_pkg.sv
// Shared types and constants for the shift-and-add-3 binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_e;

  localparam int unsigned DIGIT_W        = 4;
  localparam logic [3:0]  BLANK_CODE     = 4'hF;
  localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADD3_THRESHOLD) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/bcd_shift_converter.sv
// Iterative binary-to-BCD converter (double dabble) with valid/ready input and registered outputs.
// Optional leading-zero blanking: define BCD_LEADING_BLANK_EN.
module bcd_shift_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    btn_reset,
  input  logic [WIDTH-1:0]        bin_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic                    out_valid
);

  localparam int unsigned SCR_W = DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = SCR_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  if ((64'd10 ** DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
    $error("bcd_shift_converter: DIGITS too small for WIDTH");
  end

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [SCR_W-1:0]  bcd_q, bcd_d;
  logic              valid_q, valid_d;

  logic [SCR_W-1:0]  scr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic [SCR_W-1:0]  bcd_fmt;
  logic              accept;
  logic              last_iter;

  assign accept    = ready_q && in_valid && (state_q == IDLE);
  assign last_iter = (state_q == CONVERT) && (cnt_q == LAST_ITER);

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (sr_q[WIDTH + DIGIT_W*g +: DIGIT_W]),
      .digit_o (scr_adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  assign sr_shift = {scr_adj, sr_q[WIDTH-1:0]} << 1;

  always_comb begin
    bcd_fmt = sr_shift[SR_W-1:WIDTH];
`ifdef BCD_LEADING_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // Walk from the top digit down; digit 0 always shows.
      for (int unsigned k = 1; k < DIGITS; k++) begin
        if (lead && (bcd_fmt[DIGIT_W*(DIGITS-k) +: DIGIT_W] == '0))
          bcd_fmt[DIGIT_W*(DIGITS-k) +: DIGIT_W] = BLANK_CODE;
        else
          lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = CONVERT;
      CONVERT: if (last_iter) state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    ready_d = (state_d == IDLE);
    if (accept) begin
      sr_d  = {{SCR_W{1'b0}}, bin_in};
      cnt_d = '0;
    end else if (state_q == CONVERT) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        bcd_d   = bcd_fmt;
        valid_d = 1'b1;
      end
    end
  end

  assign in_ready  = ready_q;
  assign bcd_out   = bcd_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bcd_shift_converter.sv
// Directed self-checking bench for bcd_shift_converter (default 8-bit / 3-digit build).
module tb_bcd_shift_converter;

  logic        clk;
  logic        btn_reset;
  logic [7:0]  bin_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd_out;
  logic        out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_shift_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [11:0] exp_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
`ifdef BCD_LEADING_BLANK_EN
    if (h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
`endif
    return {h, t, u};
  endfunction

  task automatic start(input logic [7:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    bin_in   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic rdy_low);
    lat     = 0;
    rdy_low = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && in_ready) rdy_low = 1'b0;
    end while (!out_valid && lat < 30);
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
  endtask

  task automatic conv(input int v, input string tag);
    int   lat;
    logic rl;
    start(8'(v));
    wait_done(lat, rl);
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd(v)));
  endtask

  initial begin
    int   lat, lat2, nv;
    logic rl;

    btn_reset = 1'b0;
    in_valid  = 1'b0;
    bin_in    = '0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd_out",   32'(bcd_out),   32'd0);
    #10 btn_reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(in_ready), 32'd1);

    conv(0, "zero");
    @(posedge clk); #1;
    chk("zero_pulse_one_cycle", 32'(out_valid), 32'd0);

    start(8'd255);
    wait_done(lat, rl);
    chk("v255_latency", 32'(lat), 32'd8);
    chk("v255_bcd", 32'(bcd_out), 32'h255);
    chk("v255_ready_low", 32'(rl), 32'd1);
    chk("v255_ready_with_valid", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("v255_pulse_one_cycle", 32'(out_valid), 32'd0);
    chk("v255_bcd_hold", 32'(bcd_out), 32'h255);

    // back-to-back with in_valid held high
    bin_in   = 8'd128;
    in_valid = 1'b1;
    @(posedge clk); #1;
    bin_in = 8'd9;
    wait_done(lat, rl);
    chk("b2b_first_latency", 32'(lat), 32'd8);
    chk("b2b_first_bcd", 32'(bcd_out), 32'h128);
    chk("b2b_ready_on_valid", 32'(in_ready), 32'd1);
    wait_done(lat2, rl);
    in_valid = 1'b0;
    chk("b2b_spacing", 32'(lat2), 32'd9);
    chk("b2b_second_bcd", 32'(bcd_out), 32'(exp_bcd(9)));
    count_valids(12, nv);
    chk("b2b_no_third", 32'(nv), 32'd0);

    // input changes during conversion are ignored
    start(8'd200);
    bin_in = 8'd77;
    wait_done(lat, rl);
    chk("hold_latency", 32'(lat), 32'd8);
    chk("hold_bcd", 32'(bcd_out), 32'h200);
    count_valids(12, nv);
    chk("hold_no_extra", 32'(nv), 32'd0);

    // reset mid-conversion
    start(8'd99);
    repeat (3) @(posedge clk);
    #1 btn_reset = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    btn_reset = 1'b1;
    count_valids(12, nv);
    chk("abort_no_valid", 32'(nv), 32'd0);
    chk("abort_bcd_after", 32'(bcd_out), 32'd0);
    conv(42, "after_abort");

    for (int v = 0; v < 256; v++) conv(v, "sweep");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
